// File: rtl/change_dispenser.sv
`default_nettype none
// change_dispenser: greedy largest-first coin ejector with a per-denomination bank inventory.
// Define DISPENSE_PRECHECK_EN to add a dry-run pass that refuses partial payouts.
module change_dispenser #(
  parameter int AMT_W      = 6,
  parameter int CNT_W      = 6,
  parameter int INIT_COUNT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amt,
  output logic             coin_valid,
  output logic [4:0]       coin_out,
  input  logic             eject_ready,
  input  logic             deposit_valid,
  input  logic [4:0]       deposit_coin,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remainder,
  output logic [4:0]       inv_empty
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_EJECT    = 3'd2,
    S_DONE     = 3'd3,
    S_PRECHECK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state, w_next;
  logic [AMT_W-1:0] r_rem;
  logic [4:0]       r_coin_out;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       w_sel;
  logic [AMT_W-1:0] w_ej_val;
  logic [4:0]       w_inc;
  logic [4:0]       w_dec;

  // Coin values in nickels, indexed in coin_out bit order.
  function automatic logic [AMT_W-1:0] f_val(input int idx);
    case (idx)
      0:       f_val = AMT_W'(1);
      1:       f_val = AMT_W'(2);
      2:       f_val = AMT_W'(5);
      3:       f_val = AMT_W'(10);
      default: f_val = AMT_W'(20);
    endcase
  endfunction

  always_comb begin
    w_sel    = '0;
    w_ej_val = '0;
    for (int i = 0; i < 5; i++) begin
      if (f_val(i) <= r_rem && r_cnt[i] != '0) w_sel = 5'b00001 << i;
      if (r_coin_out[i]) w_ej_val = f_val(i);
    end
  end

  assign w_dec = (r_state == S_EJECT && eject_ready) ? r_coin_out : 5'b00000;
  assign w_inc = (deposit_valid && $onehot(deposit_coin)) ? deposit_coin : 5'b00000;

`ifdef DISPENSE_PRECHECK_EN
  logic [AMT_W-1:0] r_dry, w_dry_next, w_pc_val, w_q;
  logic [2:0]       r_pc_idx;
  logic [CNT_W-1:0] w_pc_cnt;
  logic [31:0]      w_n;

  always_comb begin
    w_pc_val = f_val(int'(r_pc_idx));
    case (r_pc_idx)
      3'd4:    begin w_q = r_dry / AMT_W'(20); w_pc_cnt = r_cnt[4]; end
      3'd3:    begin w_q = r_dry / AMT_W'(10); w_pc_cnt = r_cnt[3]; end
      3'd2:    begin w_q = r_dry / AMT_W'(5);  w_pc_cnt = r_cnt[2]; end
      3'd1:    begin w_q = r_dry >> 1;         w_pc_cnt = r_cnt[1]; end
      default: begin w_q = r_dry;              w_pc_cnt = r_cnt[0]; end
    endcase
    w_n        = (32'(w_q) < 32'(w_pc_cnt)) ? 32'(w_q) : 32'(w_pc_cnt);
    w_dry_next = r_dry - AMT_W'(w_n * 32'(w_pc_val));
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (change_req) begin
          if (change_amt == '0) w_next = S_DONE;
`ifdef DISPENSE_PRECHECK_EN
          else w_next = S_PRECHECK;
`else
          else w_next = S_SELECT;
`endif
        end
      end
      S_SELECT: w_next = (w_sel != '0) ? S_EJECT : S_DONE;
      S_EJECT:  if (eject_ready) w_next = S_SELECT;
      S_DONE:   w_next = S_IDLE;
`ifdef DISPENSE_PRECHECK_EN
      S_PRECHECK: if (r_pc_idx == 3'd0) w_next = (w_dry_next != '0) ? S_DONE : S_SELECT;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_coin_out <= '0;
`ifdef DISPENSE_PRECHECK_EN
      r_dry      <= '0;
      r_pc_idx   <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (change_req) begin
            r_rem    <= change_amt;
`ifdef DISPENSE_PRECHECK_EN
            r_dry    <= change_amt;
            r_pc_idx <= 3'd4;
`endif
          end
        end
        S_SELECT: r_coin_out <= w_sel;
        S_EJECT: begin
          if (eject_ready) begin
            r_rem      <= (r_rem >= w_ej_val) ? r_rem - w_ej_val : '0;
            r_coin_out <= '0;
          end
        end
`ifdef DISPENSE_PRECHECK_EN
        S_PRECHECK: begin
          r_dry    <= w_dry_next;
          r_pc_idx <= r_pc_idx - 3'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  // A same-cycle deposit and ejection of one denomination cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) r_cnt[i] <= CNT_W'(INIT_COUNT);
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_inc[i] && !w_dec[i] && r_cnt[i] != c_cnt_max) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    inv_empty = '0;
    for (int i = 0; i < 5; i++) inv_empty[i] = (r_cnt[i] == '0);
  end

  assign coin_valid = (r_state == S_EJECT);
  assign coin_out   = r_coin_out;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign short      = done && (r_rem != '0);
  assign remainder  = done ? r_rem : '0;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// tb_change_dispenser: directed and randomized requests checked against a greedy change model.
module tb_change_dispenser;
  localparam int AMT_W      = 6;
  localparam int CNT_W      = 6;
  localparam int INIT_COUNT = 10;
`ifdef DISPENSE_PRECHECK_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             change_req = 1'b0;
  logic [AMT_W-1:0] change_amt = '0;
  logic             coin_valid;
  logic [4:0]       coin_out;
  logic             eject_ready = 1'b0;
  logic             deposit_valid = 1'b0;
  logic [4:0]       deposit_coin = '0;
  logic             busy, done, short;
  logic [AMT_W-1:0] remainder;
  logic [4:0]       inv_empty;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) dut (
    .clk(clk), .reset(reset), .change_req(change_req), .change_amt(change_amt),
    .coin_valid(coin_valid), .coin_out(coin_out), .eject_ready(eject_ready),
    .deposit_valid(deposit_valid), .deposit_coin(deposit_coin), .busy(busy), .done(done),
    .short(short), .remainder(remainder), .inv_empty(inv_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mcnt [5];
  int vals [5] = '{1, 2, 5, 10, 20};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_empty();
    int r = 0;
    for (int i = 0; i < 5; i++) if (mcnt[i] == 0) r |= (1 << i);
    return r;
  endfunction

  function automatic void m_deposit(input logic [4:0] c);
    if ($onehot(c))
      for (int i = 0; i < 5; i++) if (c[i] && mcnt[i] < (1 << CNT_W) - 1) mcnt[i]++;
  endfunction

  // dep_idx >= 0 deposits that denomination on the cycle of its own ejection handshake.
  task automatic req(input int amt, input int hold, input int dep_idx);
    int  coins[$];
    int  tmp [5];
    int  rem, exp_rem, cycles, held;
    bit  found, first, got_done;
    tmp = mcnt;
    rem = amt;
    do begin
      found = 0;
      for (int d = 4; d >= 0; d--)
        if (!found && vals[d] <= rem && tmp[d] > 0) begin
          found = 1; coins.push_back(d); tmp[d]--; rem -= vals[d];
        end
    end while (found);
    exp_rem = rem;
`ifdef DISPENSE_PRECHECK_EN
    if (rem != 0) begin coins.delete(); exp_rem = amt; end
`endif
    @(negedge clk);
    change_req = 1'b1; change_amt = AMT_W'(amt); eject_ready = 1'b0;
    @(negedge clk);
    change_req = 1'b0;
    cycles = 1; held = 0; first = 1; got_done = 0;
    chk("busy_accept", 32'(busy), 1);
    while (!got_done && cycles < 400) begin
      eject_ready = 1'b0; deposit_valid = 1'b0;
      if (done) begin
        got_done = 1;
        chk("short", 32'(short), 32'(exp_rem != 0));
        chk("remainder", 32'(remainder), exp_rem);
        chk("coins_left", coins.size(), 0);
        chk("busy_in_done", 32'(busy), 1);
      end else if (coin_valid) begin
        if (first) begin chk("first_latency", cycles, LAT); first = 0; end
        if (coins.size() == 0) begin
          chk("extra_coin_valid", 32'(coin_valid), 0);
          eject_ready = 1'b1;
        end else begin
          chk("coin_out", 32'(coin_out), 1 << coins[0]);
          if (held < hold) held++;
          else begin
            eject_ready = 1'b1; held = 0;
            mcnt[coins[0]]--;
            if (dep_idx == coins[0]) begin
              deposit_valid = 1'b1; deposit_coin = 5'b00001 << dep_idx; mcnt[dep_idx]++;
            end
            void'(coins.pop_front());
          end
        end
      end
      @(negedge clk);
      cycles++;
    end
    eject_ready = 1'b0; deposit_valid = 1'b0;
    if (!got_done) chk("done_timeout", 32'(done), 1);
    else begin
      chk("done_pulse_width", 32'(done), 0);
      chk("busy_after_done", 32'(busy), 0);
      chk("inv_empty", 32'(inv_empty), m_empty());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) mcnt[i] = INIT_COUNT;
    repeat (2) @(negedge clk);
    chk("rst_coin_valid", 32'(coin_valid), 0);
    chk("rst_coin_out", 32'(coin_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_short", 32'(short), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_inv_empty", 32'(inv_empty), 0);
    reset = 1'b0;

    req(19, 0, -1);
    req(5, 3, -1);
    while (mcnt[2] > 0) req(5, 0, -1);
    req(6, 0, -1);
    chk("quarter_empty", 32'(inv_empty[2]), 1);
    while (mcnt[0] > 0) req(1, 0, -1);
    req(3, 0, -1);
    req(0, 0, -1);

    req(2, 0, 1);
    @(negedge clk); deposit_valid = 1'b1; deposit_coin = 5'b01100; m_deposit(5'b01100);
    @(negedge clk); deposit_valid = 1'b0;
    chk("non_onehot_deposit", 32'(inv_empty), m_empty());
    while (mcnt[1] > 0) req(2, 0, -1);
    req(2, 0, -1);

    @(negedge clk); change_req = 1'b1; change_amt = AMT_W'(20); eject_ready = 1'b0;
    @(negedge clk); change_req = 1'b0;
    for (int k = 0; k < 20 && !coin_valid; k++) @(negedge clk);
    chk("pre_reset_valid", 32'(coin_valid), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_coin_valid", 32'(coin_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_coin_out", 32'(coin_out), 0);
    chk("midrst_inv_empty", 32'(inv_empty), 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 5; i++) mcnt[i] = INIT_COUNT;
    repeat (4) begin @(negedge clk); chk("no_done_after_reset", 32'(done), 0); end
    req(20, 0, -1);

    repeat (30) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        deposit_valid = 1'b1;
        deposit_coin  = 5'($urandom_range(0, 31));
        m_deposit(deposit_coin);
      end
      @(negedge clk); deposit_valid = 1'b0;
      req($urandom_range(0, 63), $urandom_range(0, 2), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
